// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
// The producer drives data/valid; the transmitter answers with ready.
interface uart_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register, so the upstream can
// queue the next byte while the current frame is still on the wire.
module uart_tx #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 38400000
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     soft_reset_i,
    uart_tx_if.slave up_if,
    output logic     tx_o,
    output logic     busy_o,
    output logic     done_o
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       hold_q;
    logic             hold_full_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;

    logic accept;
    logic bit_end;

    assign accept      = up_if.valid && !hold_full_q;
    assign bit_end     = (cnt_q == CNT_LAST);
    assign up_if.ready = !hold_full_q;
    assign tx_o        = tx_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    // Line outputs are registered from the current state, so they trail the
    // state by one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data registers are reset too; they are only a few flops
            // and this keeps the soft and hard reset paths identical.
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (soft_reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so a later assignment to
            // hold_full_q in the case below wins over the accept above.
            if (accept) begin
                hold_q      <= up_if.data;
                hold_full_q <= 1'b1;
            end

            tx_q   <= 1'b1;
            busy_q <= (state_q != IDLE);
            done_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        shift_q     <= hold_q;
                        hold_full_q <= 1'b0;
                        cnt_q       <= '0;
                        bit_idx_q   <= '0;
                        state_q     <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (bit_end) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    tx_q <= shift_q[bit_idx_q];
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        done_q <= 1'b1;
                        cnt_q  <= '0;
                        if (hold_full_q) begin
                            shift_q     <= hold_q;
                            hold_full_q <= 1'b0;
                            bit_idx_q   <= '0;
                            state_q     <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-schedule model predicts tx/busy/done/ready every
// cycle, and a loopback receiver decodes the line back into bytes.
module tb_uart_tx;
    localparam int CLOCK_FREQ = 160000;
    localparam int BAUD_RATE  = 10000;
    localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
    localparam int FRAME      = 10 * CPB;

    logic clk        = 1'b0;
    logic rst        = 1'b0;
    logic soft_reset = 1'b0;
    logic tx;
    logic busy;
    logic done;

    uart_tx_if u_if ();

    uart_tx #(.BAUD_RATE(BAUD_RATE), .CLOCK_FREQ(CLOCK_FREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .soft_reset_i(soft_reset),
        .up_if       (u_if),
        .tx_o        (tx),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: each accepted byte gets a frame whose first low cycle follows edge s.
    // The byte leaves the holding register at edge s-1.
    typedef struct {
        int         s;
        logic [7:0] b;
    } frame_t;

    frame_t     frames[$];
    logic [7:0] exp_rx[$];
    int         pend_p = -1;
    int         last_p = -100000;
    bit         m_acc  = 1'b0;

    function automatic bit m_ready(int k);
        return !(pend_p >= 0 && k < pend_p);
    endfunction

    task automatic model_clear();
        frames.delete();
        pend_p = -1;
        last_p = -100000;
    endtask

    task automatic model_edge();
        int p;
        cyc++;
        m_acc = 1'b0;
        if (rst || soft_reset) begin
            model_clear();
        end else if (u_if.valid && m_ready(cyc - 1)) begin
            p = (cyc + 1 > last_p + FRAME) ? cyc + 1 : last_p + FRAME;
            frames.push_back('{s: p + 1, b: u_if.data});
            pend_p = p;
            last_p = p;
            m_acc  = 1'b1;
        end
    endtask

    task automatic expect_outputs(output logic e_tx, output logic e_busy, output logic e_done);
        int off;
        int bit_no;
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        while (frames.size() != 0 && cyc >= frames[0].s + FRAME) void'(frames.pop_front());
        foreach (frames[i]) begin
            off = cyc - frames[i].s;
            if (off >= 0 && off < FRAME) begin
                bit_no = off / CPB;
                e_busy = 1'b1;
                if (bit_no == 0)      e_tx = 1'b0;
                else if (bit_no == 9) e_tx = 1'b1;
                else                  e_tx = frames[i].b[bit_no - 1];
                if (off == FRAME - 1) begin
                    e_done = 1'b1;
                    exp_rx.push_back(frames[i].b);
                end
            end
        end
    endtask

    // Observed-waveform statistics used for the hand-computed expectations.
    int   busy_cycles, busy_rises, done_cnt, done_last, done_prev, first_low;
    logic prev_tx   = 1'b1;
    logic prev_busy = 1'b0;

    task automatic stats_clear();
        busy_cycles = 0;
        busy_rises  = 0;
        done_cnt    = 0;
        done_last   = 0;
        done_prev   = 0;
        first_low   = -1;
    endtask

    task automatic step();
        logic e_tx, e_busy, e_done;
        @(posedge clk);
        model_edge();
        #2;
        expect_outputs(e_tx, e_busy, e_done);
        check("tx", tx, e_tx);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("ready", u_if.ready, m_ready(cyc));
        if (busy === 1'b1 && prev_busy !== 1'b1) busy_rises++;
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) begin
            done_cnt++;
            done_prev = done_last;
            done_last = cyc;
        end
        if (tx === 1'b0 && prev_tx === 1'b1 && first_low < 0) first_low = cyc;
        prev_tx   = tx;
        prev_busy = busy;
    endtask

    task automatic send_byte(logic [7:0] b);
        bit got;
        got        = 1'b0;
        u_if.valid = 1'b1;
        u_if.data  = b;
        for (int i = 0; i < 400 && !got; i++) begin
            step();
            got = m_acc;
        end
        u_if.valid = 1'b0;
        check("accept", got, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((frames.size() != 0 || !m_ready(cyc)) && n < 2000) begin
            step();
            n++;
        end
        check("drain", n < 2000, 1);
    endtask

    task automatic wait_frame_offset(int off);
        int n;
        n = 0;
        while (!(frames.size() != 0 && cyc - frames[0].s == off) && n < 1000) begin
            step();
            n++;
        end
        check("reach_offset", n < 1000, 1);
    endtask

    // Loopback receiver: samples mid-bit, delivers a byte at the end of the stop bit.
    logic [7:0] rx_last = '0;
    int         rx_cnt  = 0;

    initial begin : rx_loop
        int         n;
        logic [7:0] sh;
        logic       stop_bit;
        bit         act;
        logic [8:0] want;
        n        = 0;
        sh       = '0;
        stop_bit = 1'b0;
        act      = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || soft_reset) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx === 1'b0) begin
                    act = 1'b1;
                    n   = 0;
                end
            end else begin
                n++;
                if (n == CPB / 2 && tx !== 1'b0) begin
                    act = 1'b0;
                end else if (n >= CPB + CPB / 2 && n < 9 * CPB && (n - CPB / 2) % CPB == 0) begin
                    sh[(n - CPB - CPB / 2) / CPB] = tx;
                end else if (n == 9 * CPB + CPB / 2) begin
                    stop_bit = tx;
                end else if (n == FRAME - 1) begin
                    act  = 1'b0;
                    want = (exp_rx.size() != 0) ? {1'b0, exp_rx.pop_front()} : 9'h100;
                    check("rx_byte", {1'b0, sh}, want);
                    check("rx_stop", stop_bit, 1);
                    rx_last = sh;
                    rx_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc_cyc;
        int acc_total;
        int rx_before;
        int gap;
        u_if.valid = 1'b0;
        u_if.data  = '0;
        stats_clear();

        // Asynchronous reset between clock edges.
        #3;
        rst = 1'b1;
        model_clear();
        #1;
        check("rst_tx", tx, 1);
        check("rst_ready", u_if.ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();

        // Single byte 0xA5.
        stats_clear();
        send_byte(8'hA5);
        acc_cyc = cyc;
        wait_idle();
        repeat (4) step();
        check("a5_latency", first_low - acc_cyc, 2);
        check("a5_busy_cycles", busy_cycles, 160);
        check("a5_busy_rises", busy_rises, 1);
        check("a5_done_count", done_cnt, 1);
        check("a5_done_pos", done_last - first_low, 159);
        check("a5_rx", rx_last, 8'hA5);

        // Back-to-back 0x00 then 0xFF.
        stats_clear();
        send_byte(8'h00);
        send_byte(8'hFF);
        wait_idle();
        repeat (4) step();
        check("b2b_busy_cycles", busy_cycles, 320);
        check("b2b_busy_rises", busy_rises, 1);
        check("b2b_done_count", done_cnt, 2);
        check("b2b_done_gap", done_last - done_prev, 160);
        check("b2b_rx", rx_last, 8'hFF);

        // valid held high with 0x3C for 400 cycles.
        stats_clear();
        acc_total  = 0;
        u_if.valid = 1'b1;
        u_if.data  = 8'h3C;
        repeat (400) begin
            step();
            acc_total += int'(m_acc);
        end
        u_if.valid = 1'b0;
        wait_idle();
        repeat (4) step();
        check("bp_accepts", acc_total, 4);
        check("bp_frames", done_cnt, acc_total);
        check("bp_rx", rx_last, 8'h3C);

        // soft_reset during data bit 4 of 0x81 with 0x7E queued.
        stats_clear();
        rx_before = rx_cnt;
        send_byte(8'h81);
        send_byte(8'h7E);
        wait_frame_offset(5 * CPB + 5);
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        check("srst_tx", tx, 1);
        check("srst_busy", busy, 0);
        check("srst_ready", u_if.ready, 1);
        repeat (200) step();
        check("srst_done", done_cnt, 0);
        check("srst_no_rx", rx_cnt - rx_before, 0);
        stats_clear();
        send_byte(8'h42);
        wait_idle();
        repeat (4) step();
        check("srst_after_done", done_cnt, 1);
        check("srst_after_rx", rx_last, 8'h42);

        // rst in the middle of the stop bit.
        stats_clear();
        send_byte(8'hC3);
        wait_frame_offset(9 * CPB + 6);
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        check("rst_stop_tx", tx, 1);
        check("rst_stop_busy", busy, 0);
        check("rst_stop_done_now", done, 0);
        check("rst_stop_ready", u_if.ready, 1);
        repeat (2) step();
        rst = 1'b0;
        repeat (200) step();
        check("rst_stop_done", done_cnt, 0);

        // Random bytes with random gaps, including back-to-back offers.
        repeat (25) begin
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 200));
            repeat (gap) step();
            send_byte(8'($urandom_range(0, 255)));
        end
        wait_idle();
        repeat (20) step();
        check("rx_all_received", exp_rx.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
